// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit
// Description : Tracks EX/MEM/WB register tags and produces operand-forward
//               selects, load-use stalls, branch flushes and saturating hazard
//               counters. Define HAZARD_FORWARDING_EN to enable forwarding;
//               otherwise every RAW hazard is resolved by stalling.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic [1:0]       id_result_src,
    input  logic             ex_pc_src,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] c_FWD_RF   = 2'b00;
    localparam logic [1:0] c_FWD_WB   = 2'b01;
    localparam logic [1:0] c_FWD_MEM  = 2'b10;
    localparam logic [1:0] c_SRC_LOAD = 2'b01;

    logic [4:0]       ex_rs1_q, ex_rs1_d;
    logic [4:0]       ex_rs2_q, ex_rs2_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic             ex_reg_write_q, ex_reg_write_d;
    logic [1:0]       ex_result_src_q, ex_result_src_d;
    logic             ex_valid_q, ex_valid_d;
    logic [4:0]       mem_rd_q, mem_rd_d;
    logic             mem_reg_write_q, mem_reg_write_d;
    logic             mem_valid_q, mem_valid_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             wb_reg_write_q, wb_reg_write_d;
    logic             wb_valid_q, wb_valid_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic             w_hazard;

    // x0 is hardwired zero, so a stage targeting it never produces a value.
    function automatic logic stage_writes(input logic       valid,
                                          input logic       reg_write,
                                          input logic [4:0] rd,
                                          input logic [4:0] r);
        return valid && reg_write && (rd == r) && (r != 5'd0);
    endfunction

`ifdef HAZARD_FORWARDING_EN
    always_comb begin
        forward_a_e = c_FWD_RF;
        forward_b_e = c_FWD_RF;
        if (ex_valid_q) begin
            if (stage_writes(mem_valid_q, mem_reg_write_q, mem_rd_q, ex_rs1_q))
                forward_a_e = c_FWD_MEM;
            else if (stage_writes(wb_valid_q, wb_reg_write_q, wb_rd_q, ex_rs1_q))
                forward_a_e = c_FWD_WB;
            if (stage_writes(mem_valid_q, mem_reg_write_q, mem_rd_q, ex_rs2_q))
                forward_b_e = c_FWD_MEM;
            else if (stage_writes(wb_valid_q, wb_reg_write_q, wb_rd_q, ex_rs2_q))
                forward_b_e = c_FWD_WB;
        end
        // Only a load still in EX cannot be bypassed in time.
        w_hazard = id_valid && (ex_result_src_q == c_SRC_LOAD) &&
                   (stage_writes(ex_valid_q, ex_reg_write_q, ex_rd_q, id_rs1) ||
                    stage_writes(ex_valid_q, ex_reg_write_q, ex_rd_q, id_rs2));
    end
`else
    logic w_unused_tags;
    assign w_unused_tags = ^{ex_rs1_q, ex_rs2_q, ex_result_src_q, c_FWD_WB,
                             c_FWD_MEM, c_SRC_LOAD};

    always_comb begin
        forward_a_e = c_FWD_RF;
        forward_b_e = c_FWD_RF;
        // Without bypass paths the reader waits until its producer has retired.
        w_hazard = id_valid &&
                   (stage_writes(ex_valid_q,  ex_reg_write_q,  ex_rd_q,  id_rs1) ||
                    stage_writes(ex_valid_q,  ex_reg_write_q,  ex_rd_q,  id_rs2) ||
                    stage_writes(mem_valid_q, mem_reg_write_q, mem_rd_q, id_rs1) ||
                    stage_writes(mem_valid_q, mem_reg_write_q, mem_rd_q, id_rs2) ||
                    stage_writes(wb_valid_q,  wb_reg_write_q,  wb_rd_q,  id_rs1) ||
                    stage_writes(wb_valid_q,  wb_reg_write_q,  wb_rd_q,  id_rs2));
    end
`endif

    // A taken branch squashes the stalled instruction anyway, so it overrides.
    assign stall_f     = w_hazard && !ex_pc_src;
    assign stall_d     = w_hazard && !ex_pc_src;
    assign flush_d     = ex_pc_src;
    assign flush_e     = w_hazard || ex_pc_src;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

    always_comb begin
        ex_rs1_d        = id_rs1;
        ex_rs2_d        = id_rs2;
        ex_rd_d         = id_rd;
        ex_reg_write_d  = id_reg_write;
        ex_result_src_d = id_result_src;
        ex_valid_d      = id_valid && !flush_e;
        mem_rd_d        = ex_rd_q;
        mem_reg_write_d = ex_reg_write_q;
        mem_valid_d     = ex_valid_q;
        wb_rd_d         = mem_rd_q;
        wb_reg_write_d  = mem_reg_write_q;
        wb_valid_d      = mem_valid_q;
        stall_count_d   = stall_count_q;
        flush_count_d   = flush_count_q;
        if (stall_d && (stall_count_q != {CNT_W{1'b1}}))
            stall_count_d = stall_count_q + 1'b1;
        if (flush_e && (flush_count_q != {CNT_W{1'b1}}))
            flush_count_d = flush_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        ex_rs1_q        <= ex_rs1_d;
        ex_rs2_q        <= ex_rs2_d;
        ex_rd_q         <= ex_rd_d;
        ex_reg_write_q  <= ex_reg_write_d;
        ex_result_src_q <= ex_result_src_d;
        mem_rd_q        <= mem_rd_d;
        mem_reg_write_q <= mem_reg_write_d;
        wb_rd_q         <= wb_rd_d;
        wb_reg_write_q  <= wb_reg_write_d;
        if (rst) begin
            ex_valid_q    <= 1'b0;
            mem_valid_q   <= 1'b0;
            wb_valid_q    <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            mem_valid_q   <= mem_valid_d;
            wb_valid_q    <= wb_valid_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

endmodule
`default_nettype wire
